regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port GPR file, successor to the fixed 32x32 three-read-port register file.
- Configurable data width, depth and read-port count.
- Adds a per-register pending-write scoreboard for load/long-latency hazard detection, and a post-reset sequential clear FSM so the array can map to distributed RAM.
- Sits between decode (read/issue) and writeback (write) in the CPU pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries.
- NREAD, 3, number of asynchronous read ports (1..8).
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero: never written, never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NREAD  scoreboard bit of each addressed register.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue of an instruction with a pending destination.
- iss_addr  in  ADDR_W  pending destination address.
- ready  out  1  high once the clear sequence has finished.

Behaviour:
- Reset is synchronous and active-high on clk: rst sampled high at a rising edge of clk takes effect at that edge.
- Reset effect:
  - state <= CLEAR, clr_ptr <= 0, ready <= 0.
  - All busy bits cleared immediately.
  - Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes 0 to regs[clr_ptr] and increments clr_ptr.
  - When clr_ptr == DEPTH-1, that entry is written, state <= RUN and ready <= 1 at the same edge.
  - ready therefore rises exactly DEPTH cycles after the first edge with rst low.
- FSM RUN: normal operation; stays in RUN until rst.
- rst asserted during CLEAR or RUN restarts CLEAR from clr_ptr = 0.
- While ready = 0:
  - wr_en and iss_en are ignored.
  - rd_data forced to 0 and rd_busy forced to 0 on all ports.
- Reads: combinational; rd_data[k] = regs[rd_addr[k]]. With ZERO_REG=1, address 0 always reads 0.
- Writes: on an edge with ready && wr_en && !(ZERO_REG && wr_addr == 0), regs[wr_addr] <= wr_data.
- Scoreboard, one bit per entry:
  - iss_en sets busy[iss_addr]; wr_en clears busy[wr_addr].
  - Both take effect at the edge and are gated by ready.
  - Same address, same cycle, iss_en and wr_en both high: set wins (the newer producer is pending); the data write still occurs.
  - With ZERO_REG=1, busy[0] is constant 0.
  - iss_en to an already-busy entry leaves it busy; no count is kept, so a single producer per register is the pipeline's responsibility.
  - wr_en to a non-busy entry is legal; the data is written and busy stays 0.
- rd_busy[k] = busy[rd_addr[k]] (combinational), subject to the optional bypass below.
- Latency: write visible on read ports the cycle after the write edge (0 cycles with bypass).
- Multiple read ports with the same address return identical values.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - When ready && wr_en && the write is not to zero-reg 0 && rd_addr[k] == wr_addr, rd_data[k] = wr_data combinationally (write-through in the write cycle).
  - rd_busy[k] = 0 for that port, unless iss_en targets the same address in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads in the write cycle return the old value.
  - rd_busy reflects the current busy bit.
  - The pipeline must then stall one extra cycle on writeback hazards.

Test Plan:
- Reset then idle, DEPTH=32 -> ready low for exactly 32 cycles, then high; all rd_data read 0; rd_busy all 0.
- ready high, write 0xDEADBEEF to r5, then rd_addr0=5 next cycle -> rd_data0=0xDEADBEEF. Write 0x12345678 to r0 -> r0 still reads 0.
- iss_en r7, then rd_addr1=7 -> rd_busy1=1. Then wr_en r7 with data 0xA5A5A5A5 -> rd_busy1=0 next cycle and data 0xA5A5A5A5. Simultaneous iss_en r7 and wr_en r7 -> busy stays 1 and data written.
- rst asserted for 1 cycle mid-CLEAR (at clr_ptr=10), and again after writing r3=0x55 -> ready low another 32 cycles; r3 reads 0 afterwards; writes and issues during CLEAR have no effect.
- REGFILE_BYPASS_EN defined: wr_en r9=0x0F0F0F0F with rd_addr2=9 in the same cycle -> rd_data2=0x0F0F0F0F in that cycle. Undefined: old value in that cycle, new value next cycle.
- NREAD=4, all ports rd_addr=31 after writing r31=0xFFFFFFFF -> all four rd_data equal 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port GPR file with a pending-write scoreboard and a post-reset sequential clear.
// Optional write-through read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    ready
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic              ZERO_EN  = (ZERO_REG != 32'sd0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  clr_ptr_r;
    logic [ADDR_W-1:0]  clr_ptr_nxt_s;
    logic               ready_r;
    logic               ready_nxt_s;
    logic               clr_we_s;

    // Array is left unreset so it can map onto distributed RAM; the clear FSM zeroes it instead.
    logic [DATA_W-1:0]  regs_r [DEPTH];
    logic [DEPTH-1:0]   busy_r;
    logic [DEPTH-1:0]   busy_nxt_s;

    logic               wr_fire_s;
    logic               iss_fire_s;
    logic [DATA_W-1:0]  port_data_s [NREAD];
    logic [NREAD-1:0]   port_busy_s;

    // Qualified writeback and issue strobes; entry 0 is excluded when it is hardwired to zero.
    always_comb begin
        wr_fire_s  = ready_r && wr_en  && !(ZERO_EN && (wr_addr  == '0));
        iss_fire_s = ready_r && iss_en && !(ZERO_EN && (iss_addr == '0));
    end

    // Clear FSM next-state logic: walk every entry once, then run until the next reset.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        ready_nxt_s   = ready_r;
        clr_we_s      = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_we_s      = 1'b1;
                clr_ptr_nxt_s = clr_ptr_r + 1'b1;
                if (clr_ptr_r == LAST_PTR) begin
                    state_nxt_s = ST_RUN;
                    ready_nxt_s = 1'b1;
                end else begin
                    ready_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                ready_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_ptr_nxt_s = '0;
                ready_nxt_s   = 1'b0;
            end
        endcase
    end

    // Clear FSM state, pointer and ready registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    // Register array write port, shared between the clear sequence and writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we_s) begin
                regs_r[clr_ptr_r] <= '0;
            end else if (wr_fire_s) begin
                regs_r[wr_addr] <= wr_data;
            end
        end
    end

    // Scoreboard update: issue is applied after writeback so a same-address set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_fire_s) begin
            busy_nxt_s[wr_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (iss_fire_s) begin
            busy_nxt_s[iss_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Scoreboard register; reset drops every pending producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports, blanked until the clear sequence completes.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            port_data_s[k] = '0;
            port_busy_s[k] = 1'b0;
            if (!ready_r) begin
                port_data_s[k] = '0;
                port_busy_s[k] = 1'b0;
            end else if (ZERO_EN && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
                port_data_s[k] = '0;
                port_busy_s[k] = 1'b0;
            end else begin
                port_data_s[k] = regs_r[rd_addr[k*ADDR_W +: ADDR_W]];
                port_busy_s[k] = busy_r[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                if (wr_fire_s && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)) begin
                    port_data_s[k] = wr_data;
                    port_busy_s[k] = iss_fire_s && (iss_addr == wr_addr);
                end else begin
                    port_busy_s[k] = port_busy_s[k];
                end
`endif
            end
        end
    end

    // Pack per-port results onto the flat output buses.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NREAD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = port_data_s[k];
        end
        rd_busy = port_busy_s;
        ready   = ready_r;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32x32, four read ports, zero register enabled).
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             ready;

    int total = 0;
    int bad   = 0;
    int ncyc;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {28'd0, rd_busy}, 32'd0);

        // writes and issues during CLEAR must be ignored
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_1111;
        iss_en = 1'b1; iss_addr = 5'd6;
        wait_ready(ncyc);
        wr_en = 1'b0; iss_en = 1'b0;
        chk("clear_len", ncyc, 32'd32);
        set_rd(0, 5'd5); set_rd(1, 5'd6); set_rd(2, 5'd17); set_rd(3, 5'd31);
        #1;
        chk("clr_r5", rdd(0), 32'd0);
        chk("clr_r17", rdd(2), 32'd0);
        chk("clr_r31", rdd(3), 32'd0);
        chk("clr_busy", {28'd0, rd_busy}, 32'd0);

        // basic write then read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r5_same_cyc", rdd(0), 32'hDEAD_BEEF);
`else
        chk("r5_same_cyc", rdd(0), 32'd0);
`endif
        cyc();
        wr_en = 1'b0;
        #1;
        chk("r5_read", rdd(0), 32'hDEAD_BEEF);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; set_rd(0, 5'd0);
        cyc();
        wr_en = 1'b0;
        #1;
        chk("r0_zero", rdd(0), 32'd0);

        // scoreboard set / clear / simultaneous
        iss_en = 1'b1; iss_addr = 5'd7; set_rd(1, 5'd7);
        cyc();
        iss_en = 1'b0;
        #1;
        chk("r7_busy", {31'd0, rd_busy[1]}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_wb_busy_now", {31'd0, rd_busy[1]}, 32'd0);
        chk("r7_wb_data_now", rdd(1), 32'hA5A5_A5A5);
`else
        chk("r7_wb_busy_now", {31'd0, rd_busy[1]}, 32'd1);
        chk("r7_wb_data_now", rdd(1), 32'd0);
`endif
        cyc();
        wr_en = 1'b0;
        #1;
        chk("r7_wb_busy", {31'd0, rd_busy[1]}, 32'd0);
        chk("r7_wb_data", rdd(1), 32'hA5A5_A5A5);

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h3C3C_3C3C;
        iss_en = 1'b1; iss_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_both_busy_now", {31'd0, rd_busy[1]}, 32'd1);
        chk("r7_both_data_now", rdd(1), 32'h3C3C_3C3C);
`else
        chk("r7_both_busy_now", {31'd0, rd_busy[1]}, 32'd0);
        chk("r7_both_data_now", rdd(1), 32'hA5A5_A5A5);
`endif
        cyc();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        chk("r7_both_busy", {31'd0, rd_busy[1]}, 32'd1);
        chk("r7_both_data", rdd(1), 32'h3C3C_3C3C);

        // same-cycle read of the write address on port 2
        set_rd(2, 5'd9);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0F0F_0F0F;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r9_same_cyc", rdd(2), 32'h0F0F_0F0F);
`else
        chk("r9_same_cyc", rdd(2), 32'd0);
`endif
        cyc();
        wr_en = 1'b0;
        #1;
        chk("r9_next", rdd(2), 32'h0F0F_0F0F);

        // all four ports on the same address
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF_FFFF;
        cyc();
        wr_en = 1'b0;
        for (int k = 0; k < NR; k++) set_rd(k, 5'd31);
        #1;
        chk("r31_p0", rdd(0), 32'hFFFF_FFFF);
        chk("r31_p1", rdd(1), 32'hFFFF_FFFF);
        chk("r31_p2", rdd(2), 32'hFFFF_FFFF);
        chk("r31_p3", rdd(3), 32'hFFFF_FFFF);

        // reset after a write, then again mid-clear
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
        cyc();
        wr_en = 1'b0; set_rd(0, 5'd3);
        #1;
        chk("r3_pre", rdd(0), 32'h0000_0055);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444_4444;
        iss_en = 1'b1; iss_addr = 5'd4;
        for (int i = 0; i < 10; i++) cyc();
        chk("mid_clear_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_ready(ncyc);
        wr_en = 1'b0; iss_en = 1'b0;
        chk("clear_len2", ncyc, 32'd32);
        set_rd(0, 5'd3); set_rd(1, 5'd4); set_rd(2, 5'd7); set_rd(3, 5'd31);
        #1;
        chk("r3_after", rdd(0), 32'd0);
        chk("r4_after", rdd(1), 32'd0);
        chk("r31_after", rdd(3), 32'd0);
        chk("busy_after", {28'd0, rd_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
